// File: rtl/ddp_hs_pkg.sv
// Shared types for the 4-phase bundled-data handshake arbiter.
package ddp_hs_pkg;

    // Arbiter FSM: idle, driving the COPY stage, relaying its Ack upstream.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RELAY = 2'd2
    } hs_state_t;

    // Width of the completed-transfer counter (wraps naturally).
    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/hs_sync.sv
// Multi-flop synchroniser for asynchronous handshake lines, async active-low clear.
module hs_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);

    logic [W-1:0] sync_q [STAGES];
    logic [W-1:0] sync_d [STAGES];

    // Shift chain: stage 0 samples the raw input, each later stage the one before.
    always_comb begin
        sync_d[0] = d_in;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Synchroniser flops, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/copy_merge_arbiter.sv
// Round-robin merge arbiter sharing one self-timed COPY stage between N_REQ sources.
// Handshakes: each source raises Send_in[i] with Data_in stable, waits for Ack_out[i],
// drops Send_in[i], then waits for Ack_out[i] to fall. The arbiter plays the same
// 4-phase protocol towards the COPY stage with Send_out/Data_out/Ack_in.
module copy_merge_arbiter
    import ddp_hs_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                       CLK,
    input  logic                       MR_n,
    input  logic [N_REQ-1:0]           Send_in,
    input  logic [N_REQ*DW-1:0]        Data_in,
    output logic [N_REQ-1:0]           Ack_out,
    output logic                       Send_out,
    output logic [DW-1:0]              Data_out,
    input  logic                       Ack_in,
    output logic [$clog2(N_REQ)-1:0]   Grant_id,
    output logic                       Busy,
    output logic                       Timeout_err,
    output logic [XFER_CNT_W-1:0]      Xfer_cnt
);

    localparam int          GW          = $clog2(N_REQ);
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

    logic [N_REQ-1:0]      ss;
    logic                  sa;
    logic [DW-1:0]         data_arr [N_REQ];

    hs_state_t             state_q, state_d;
    logic                  send_out_q, send_out_d;
    logic [N_REQ-1:0]      ack_out_q, ack_out_d;
    logic [DW-1:0]         data_out_q, data_out_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [GW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [15:0]           wdog_q, wdog_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic                  sel_vld;
    logic [GW-1:0]         sel_idx, sel_nxt, cand_idx;
    int                    cand;

    hs_sync #(.W(N_REQ), .STAGES(SYNC_STAGES)) u_send_sync (
        .clk   (CLK),
        .rst_n (MR_n),
        .d_in  (Send_in),
        .d_out (ss)
    );

    hs_sync #(.W(1), .STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (CLK),
        .rst_n (MR_n),
        .d_in  (Ack_in),
        .d_out (sa)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = Data_in[i*DW +: DW];
    end

    // Round-robin pick: first synchronised request at or after rr_ptr, wrapping.
    always_comb begin
        sel_vld  = 1'b0;
        sel_idx  = '0;
        sel_nxt  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand     = (int'(rr_ptr_q) + k) % N_REQ;
            cand_idx = GW'(cand);
            if (!sel_vld && ss[cand_idx]) begin
                sel_vld = 1'b1;
                sel_idx = cand_idx;
                sel_nxt = (cand == N_REQ - 1) ? '0 : GW'(cand + 1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a source dropping Send_in during DRIVE is simply not looked at.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_vld) state_d = DRIVE;
            DRIVE:   if (sa) state_d = RELAY;
            RELAY:   if (!sa && !ss[grant_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath: grant capture, handshake lines, watchdog, counter.
    always_comb begin
        data_out_d = data_out_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        if (state_q == IDLE && sel_vld) begin
            data_out_d = data_arr[sel_idx];
            grant_d    = sel_idx;
            rr_ptr_d   = sel_nxt;
        end

        // Send_out rises one cycle into DRIVE so Data_out is settled a cycle ahead,
        // and falls on the same edge that Ack_out rises.
        send_out_d = (state_q == DRIVE) && !sa;

        ack_out_d = '0;
        if (state_d == RELAY) begin
            ack_out_d[grant_q] = 1'b1;
        end

        xfer_cnt_d = xfer_cnt_q;
        if (state_q == RELAY && state_d == IDLE) begin
            xfer_cnt_d = xfer_cnt_q + XFER_CNT_W'(1);
        end

        wdog_d = wdog_q;
        if (state_d != state_q) begin
            wdog_d = '0;
        end else if (state_q != IDLE && wdog_q != TIMEOUT_LIM) begin
            wdog_d = wdog_q + 16'd1;
        end

        // Sticky: once raised only MR_n clears it; the FSM keeps waiting.
        timeout_err_d = timeout_err_q | (wdog_d == TIMEOUT_LIM);
    end

    // Registered outputs, watchdog and counters.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            send_out_q    <= 1'b0;
            ack_out_q     <= '0;
            data_out_q    <= '0;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
            xfer_cnt_q    <= '0;
        end else begin
            send_out_q    <= send_out_d;
            ack_out_q     <= ack_out_d;
            data_out_q    <= data_out_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
            xfer_cnt_q    <= xfer_cnt_d;
        end
    end

    assign Send_out    = send_out_q;
    assign Ack_out     = ack_out_q;
    assign Data_out    = data_out_q;
    assign Grant_id    = grant_q;
    assign Busy        = (state_q != IDLE);
    assign Timeout_err = timeout_err_q;
    assign Xfer_cnt    = xfer_cnt_q;

endmodule

// File: tb/tb_copy_merge_arbiter.sv
// Directed bench for copy_merge_arbiter: source and COPY-stage handshake models,
// a table of single-source transfers plus hand-written multi-cycle sequences.
module tb_copy_merge_arbiter;

    localparam int N_REQ       = 4;
    localparam int DW          = 32;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 10;
    localparam int COPY_DELAY  = 3;

    logic                  CLK = 1'b0;
    logic                  MR_n = 1'b0;
    logic [N_REQ-1:0]      Send_in;
    logic [N_REQ*DW-1:0]   Data_in = '0;
    logic [N_REQ-1:0]      Ack_out;
    logic                  Send_out;
    logic [DW-1:0]         Data_out;
    logic                  Ack_in;
    logic [1:0]            Grant_id;
    logic                  Busy;
    logic                  Timeout_err;
    logic [15:0]           Xfer_cnt;

    logic [N_REQ-1:0]      man_req   = '0;
    logic [N_REQ-1:0]      src_auto  = '0;
    logic                  copy_auto = 1'b1;
    longint                ack_rise_t = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               src;
        logic [DW-1:0]    data;
        logic [N_REQ-1:0] exp_ack;
        logic [15:0]      exp_cnt;
    } vec_t;

    vec_t vecs [5];
    int   fair_exp [8];

    copy_merge_arbiter #(
        .N_REQ       (N_REQ),
        .DW          (DW),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .MR_n        (MR_n),
        .Send_in     (Send_in),
        .Data_in     (Data_in),
        .Ack_out     (Ack_out),
        .Send_out    (Send_out),
        .Data_out    (Data_out),
        .Ack_in      (Ack_in),
        .Grant_id    (Grant_id),
        .Busy        (Busy),
        .Timeout_err (Timeout_err),
        .Xfer_cnt    (Xfer_cnt)
    );

    // Clock.
    always #5 CLK = ~CLK;

    // Source models: manual request level, or a free-running 4-phase requester.
    initial begin : src_model
        Send_in = '0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < N_REQ; i++) begin
                if (src_auto[i]) begin
                    if (!Send_in[i] && !Ack_out[i]) Send_in[i] = 1'b1;
                    else if (Send_in[i] && Ack_out[i]) Send_in[i] = 1'b0;
                end else begin
                    Send_in[i] = man_req[i];
                end
            end
        end
    end

    // COPY stage model: acks a few cycles after Send_out, drops Ack once Send_out falls.
    initial begin : copy_model
        int cnt;
        cnt = 0;
        Ack_in = 1'b0;
        forever begin
            @(negedge CLK);
            if (!copy_auto || !Send_out) begin
                cnt = 0;
                Ack_in = 1'b0;
            end else if (!Ack_in) begin
                cnt++;
                if (cnt >= COPY_DELAY) begin
                    Ack_in = 1'b1;
                    ack_rise_t = longint'($time);
                end
            end
        end
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    // Wait on negedges for a DUT line to reach a level: 0=Send_out, 1=Busy, 2=any Ack_out.
    task automatic wait_sig(input int sel, input logic level, input int budget,
                            output bit ok, output int n);
        logic v;
        ok = 1'b0;
        n  = 0;
        while (n < budget) begin
            @(negedge CLK);
            n++;
            case (sel)
                0:       v = Send_out;
                1:       v = Busy;
                default: v = |Ack_out;
            endcase
            if (v == level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        #2;
        MR_n      = 1'b0;
        man_req   = '0;
        src_auto  = '0;
        copy_auto = 1'b1;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1;
        MR_n = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    // One complete transfer from a single idle source.
    task automatic xfer_one(input string tag, input int src, input logic [DW-1:0] data,
                            input logic [N_REQ-1:0] exp_ack, input logic [15:0] exp_cnt);
        bit ok;
        int n;
        longint dt;
        Data_in[src*DW +: DW] = data;
        @(posedge CLK);
        #1;
        man_req[src] = 1'b1;
        @(negedge CLK);
        wait_sig(0, 1'b1, 40, ok, n);
        check({tag, " send_latency"}, 64'(n), 64'd4);
        check({tag, " data_out"}, 64'(Data_out), 64'(data));
        check({tag, " grant_id"}, 64'(Grant_id), 64'(src));
        wait_sig(2, 1'b1, 60, ok, n);
        dt = longint'($time) - ack_rise_t;
        check({tag, " ack_out"}, 64'(Ack_out), 64'(exp_ack));
        check({tag, " send_low_with_ack"}, 64'(Send_out), 64'd0);
        check({tag, " ack_latency"}, 64'(dt / 10), 64'd3);
        @(posedge CLK);
        #1;
        man_req[src] = 1'b0;
        wait_sig(1, 1'b0, 60, ok, n);
        check({tag, " back_to_idle"}, 64'(ok), 64'd1);
        check({tag, " ack_released"}, 64'(Ack_out), 64'd0);
        check({tag, " xfer_cnt"}, 64'(Xfer_cnt), 64'(exp_cnt));
        check({tag, " data_held"}, 64'(Data_out), 64'(data));
    endtask

    initial begin : global_limit
        #200000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1);
    end

    initial begin : main
        bit ok;
        int n;
        int ack_pulses;
        int send_rises;
        int overlap;
        logic prev_ack;
        logic prev_send;

        vecs[0] = '{2, 32'hDEAD_BEEF, 4'b0100, 16'd1};
        vecs[1] = '{0, 32'h1234_5678, 4'b0001, 16'd2};
        vecs[2] = '{3, 32'hA5A5_A5A5, 4'b1000, 16'd3};
        vecs[3] = '{1, 32'hFFFF_FFFF, 4'b0010, 16'd4};
        vecs[4] = '{3, 32'h0F0F_0F0F, 4'b1000, 16'd5};
        fair_exp = '{0, 1, 2, 3, 0, 1, 2, 3};

        // Reset state, during and after reset.
        repeat (2) @(negedge CLK);
        check("rst_send_out", 64'(Send_out), 64'd0);
        check("rst_ack_out", 64'(Ack_out), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        @(posedge CLK);
        #1;
        MR_n = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_outputs", 64'({Send_out, Ack_out, Data_out, Grant_id, Busy, Timeout_err, Xfer_cnt}), 64'd0);

        // Reset asserted mid-DRIVE, then the first grant goes to source 0.
        copy_auto = 1'b0;
        Data_in[3*DW +: DW] = 32'h3333_3333;
        @(posedge CLK);
        #1;
        man_req[3] = 1'b1;
        wait_sig(0, 1'b1, 40, ok, n);
        check("middrive_reached", 64'(ok), 64'd1);
        check("middrive_grant", 64'(Grant_id), 64'd3);
        @(negedge CLK);
        #2;
        MR_n = 1'b0;
        #1;
        check("middrive_send_drop", 64'(Send_out), 64'd0);
        check("middrive_busy_drop", 64'(Busy), 64'd0);
        check("middrive_data_clr", 64'(Data_out), 64'd0);
        check("middrive_grant_clr", 64'(Grant_id), 64'd0);
        man_req   = '0;
        copy_auto = 1'b1;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1;
        MR_n = 1'b1;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < N_REQ; i++) Data_in[i*DW +: DW] = 32'h1000_0000 + i;
        @(posedge CLK);
        #1;
        man_req = 4'hF;
        @(negedge CLK);
        wait_sig(0, 1'b1, 40, ok, n);
        check("postrst_latency", 64'(n), 64'd4);
        check("postrst_grant", 64'(Grant_id), 64'd0);
        check("postrst_data", 64'(Data_out), 64'h1000_0000);

        // Single-source transfer table.
        do_reset();
        for (int v = 0; v < 5; v++) begin
            xfer_one($sformatf("vec%0d", v), vecs[v].src, vecs[v].data, vecs[v].exp_ack, vecs[v].exp_cnt);
        end
        check("table_no_timeout", 64'(Timeout_err), 64'd0);

        // Fairness: all four sources continuously active.
        do_reset();
        for (int i = 0; i < N_REQ; i++) Data_in[i*DW +: DW] = 32'h2000_0000 + i;
        @(posedge CLK);
        #1;
        src_auto = 4'hF;
        for (int k = 0; k < 8; k++) begin
            wait_sig(0, 1'b1, 60, ok, n);
            check($sformatf("fair%0d grant_id", k), 64'(Grant_id), 64'(fair_exp[k]));
            check($sformatf("fair%0d data_out", k), 64'(Data_out), 64'(32'h2000_0000 + fair_exp[k]));
            check($sformatf("fair%0d xfer_cnt", k), 64'(Xfer_cnt), 64'(k));
            wait_sig(0, 1'b0, 60, ok, n);
            check($sformatf("fair%0d onehot_ack", k), 64'(Ack_out), 64'(4'b0001 << fair_exp[k]));
        end
        check("fair_no_timeout", 64'(Timeout_err), 64'd0);

        // Source 1 drops Send_in while its transfer is still in DRIVE.
        do_reset();
        Data_in[1*DW +: DW] = 32'hCAFE_F00D;
        @(posedge CLK);
        #1;
        man_req[1] = 1'b1;
        wait_sig(0, 1'b1, 40, ok, n);
        check("proto_send_seen", 64'(ok), 64'd1);
        @(posedge CLK);
        #1;
        man_req[1] = 1'b0;
        ack_pulses = 0;
        send_rises = 0;
        overlap    = 0;
        prev_ack   = 1'b0;
        prev_send  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (Ack_out[1] && !prev_ack) ack_pulses++;
            if (Send_out && !prev_send) send_rises++;
            if (Send_out && (|Ack_out)) overlap++;
            prev_ack  = Ack_out[1];
            prev_send = Send_out;
        end
        check("proto_ack_pulses", 64'(ack_pulses), 64'd1);
        check("proto_regrants", 64'(send_rises), 64'd0);
        check("proto_overlap", 64'(overlap), 64'd0);
        check("proto_xfer_cnt", 64'(Xfer_cnt), 64'd1);
        check("proto_idle", 64'(Busy), 64'd0);
        check("proto_data", 64'(Data_out), 64'hCAFE_F00D);

        // Transfer counter wrap.
        do_reset();
        force dut.xfer_cnt_q = 16'hFFFF;
        @(posedge CLK);
        @(negedge CLK);
        release dut.xfer_cnt_q;
        @(negedge CLK);
        check("wrap_preload", 64'(Xfer_cnt), 64'hFFFF);
        xfer_one("wrap", 0, 32'h0000_0001, 4'b0001, 16'h0000);

        // Watchdog: COPY stage never acks, then recovers.
        do_reset();
        copy_auto = 1'b0;
        Data_in[0*DW +: DW] = 32'h0BAD_0BAD;
        @(posedge CLK);
        #1;
        man_req[0] = 1'b1;
        wait_sig(1, 1'b1, 40, ok, n);
        check("to_busy_seen", 64'(ok), 64'd1);
        repeat (8) @(negedge CLK);
        check("to_not_yet", 64'(Timeout_err), 64'd0);
        repeat (4) @(negedge CLK);
        check("to_raised", 64'(Timeout_err), 64'd1);
        repeat (20) @(negedge CLK);
        check("to_sticky_wait", 64'(Timeout_err), 64'd1);
        check("to_still_driving", 64'(Send_out), 64'd1);
        copy_auto = 1'b1;
        wait_sig(2, 1'b1, 60, ok, n);
        check("to_ack_out", 64'(Ack_out), 64'b0001);
        @(posedge CLK);
        #1;
        man_req[0] = 1'b0;
        wait_sig(1, 1'b0, 60, ok, n);
        check("to_completed", 64'(ok), 64'd1);
        check("to_xfer_cnt", 64'(Xfer_cnt), 64'd1);
        check("to_sticky_after", 64'(Timeout_err), 64'd1);
        do_reset();
        check("to_cleared_by_reset", 64'(Timeout_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
